pico_wait_mem: RTL and testbench

PICO_WAIT_MEM -- requirements
Module: pico_wait_mem

---
 rtl/pico_wait_mem.sv | 172 +++++++++++++++++
 tb/tb_pico_wait_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pico_wait_mem.sv
// Word-addressed RAM slave for a PicoRV32-style native memory bus with a
// fixed number of wait states per access and a boot image loaded on reset.
module pico_wait_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_fault,
  output logic [31:0] instr_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;

  logic        ready_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [31:0] icount_q;

  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic [29:0] txn_waddr;
  logic [31:0] txn_wdata;
  logic [3:0]  txn_wstrb;
  logic        txn_instr;
  logic        txn_in_range;
  logic [AW-1:0] txn_idx;
  logic        in_range_q;
  logic [AW-1:0] idx_q;
  logic        unused_addr_lsbs;

  function automatic logic [31:0] boot_word(input int i);
    if (i < 31) begin
      return 32'((i + 1) << 7) | 32'h0000_0013;
    end else if (i == 31) begin
      return 32'h0000_006F;
    end
    return 32'h0;
  endfunction

  function automatic logic word_in_range(input logic [29:0] wa);
    return (wa >> AW) == 30'd0;
  endfunction

  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign accept     = (state_q == IDLE) && mem_valid;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // transaction fields come straight from the bus instead of the latches.
  assign txn_waddr    = (state_q == IDLE) ? mem_addr[31:2] : waddr_q;
  assign txn_wdata    = (state_q == IDLE) ? mem_wdata      : wdata_q;
  assign txn_wstrb    = (state_q == IDLE) ? mem_wstrb      : wstrb_q;
  assign txn_instr    = (state_q == IDLE) ? mem_instr      : instr_q;
  assign txn_in_range = word_in_range(txn_waddr);
  assign txn_idx      = txn_waddr[AW-1:0];

  assign in_range_q = word_in_range(waddr_q);
  assign idx_q      = waddr_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      waddr_q <= mem_addr[31:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      instr_q <= mem_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= boot_word(i);
      end
    end else if (enter_resp && txn_in_range && (txn_wstrb != 4'b0000)) begin
      for (int b = 0; b < 4; b++) begin
        if (txn_wstrb[b]) begin
          mem_q[txn_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
        end
      end
    end
  end

  // The response is registered on the edge leaving RESP, so the pulse lands
  // WAIT_STATES+1 edges after the accept edge and has no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      ready_q <= (state_q == RESP);
      fault_q <= (state_q == RESP) && !in_range_q;
      rdata_q <= ((state_q == RESP) && in_range_q && (wstrb_q == 4'b0000))
                 ? mem_q[idx_q] : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_q <= 32'h0;
    end else if (enter_resp && txn_instr && (txn_wstrb == 4'b0000)
                 && (icount_q != 32'hFFFF_FFFF)) begin
      icount_q <= icount_q + 32'd1;
    end
  end

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign mem_fault   = fault_q;
  assign instr_count = icount_q;

endmodule

// File: tb/tb_pico_wait_mem.sv
// Bench for pico_wait_mem: directed boot/abort/boundary steps plus randomized
// traffic, checked against a word-array reference model.
module tb_pico_wait_mem;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic        valid, instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ready, fault;
  logic [31:0] rdata, icnt;

  logic        valid0, instr0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  wstrb0;
  logic        ready0, fault0;
  logic [31:0] rdata0, icnt0;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_icnt;

  pico_wait_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(valid), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(ready), .mem_rdata(rdata), .mem_fault(fault),
    .instr_count(icnt)
  );

  pico_wait_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .mem_valid(valid0), .mem_instr(instr0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_wstrb(wstrb0),
    .mem_ready(ready0), .mem_rdata(rdata0), .mem_fault(fault0),
    .instr_count(icnt0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] boot_img(input int i);
    if (i < 31) return 32'((i + 1) * 128 + 19);
    if (i == 31) return 32'h0000_006F;
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = boot_img(i);
    ref_icnt = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/ready"}, {31'h0, ready}, 32'h0);
    check({tag, "/rdata"}, rdata, 32'h0);
    check({tag, "/fault"}, {31'h0, fault}, 32'h0);
    check({tag, "/icnt"}, icnt, 32'h0);
    check({tag, "/ready0"}, {31'h0, ready0}, 32'h0);
    check({tag, "/icnt0"}, icnt0, 32'h0);
  endtask

  // One transaction on the WAIT_STATES=2 instance; inputs are scrambled and
  // mem_valid dropped right after acceptance.
  task automatic do_txn(input logic i_instr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag,
                        output logic [31:0] got_rd, output logic got_f);
    logic        hit;
    int          idx;
    int          edges;
    logic [31:0] exp_rd;
    hit    = (a >> 2) < 32'(DEPTH);
    idx    = int'(a[7:2]);
    exp_rd = (hit && s == 4'b0000) ? ref_mem[idx] : 32'h0;
    @(negedge clk);
    valid = 1'b1; instr = i_instr; addr = a; wdata = d; wstrb = s;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom); instr = 1'($urandom);
    check({tag, "/quiet"}, {ready, fault, rdata[29:0]}, 32'h0);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ready) break;
      check({tag, "/quiet"}, {fault, rdata[30:0]}, 32'h0);
    end
    got_rd = rdata;
    got_f  = fault;
    check({tag, "/latency"}, 32'(edges), 32'(WS + 1));
    check({tag, "/rdata"}, rdata, exp_rd);
    check({tag, "/fault"}, {31'h0, fault}, {31'h0, !hit});
    if (hit && s != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    if (i_instr && s == 4'b0000 && ref_icnt != 32'hFFFF_FFFF) ref_icnt++;
    check({tag, "/icnt"}, icnt, ref_icnt);
    @(posedge clk);
    @(negedge clk);
    check({tag, "/pulse"}, {31'h0, ready}, 32'h0);
  endtask

  logic [31:0] got;
  logic        gf;
  logic [31:0] ra, rd;
  logic [3:0]  rs;
  logic [31:0] a0 [3];
  logic        i0 [3];
  logic [31:0] cnt0;

  initial begin
    reset = 1'b1;
    valid = 1'b0; instr = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    valid0 = 1'b0; instr0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; wstrb0 = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    do_txn(1'b1, 32'h0, 32'h0, 4'h0, "boot0", got, gf);
    check("boot0_word", got, 32'h0000_0093);
    check("boot0_icnt", icnt, 32'd1);
    do_txn(1'b0, 32'h7C, 32'h0, 4'h0, "jal", got, gf);
    check("jal_word", got, 32'h0000_006F);
    do_txn(1'b1, 32'h7B, 32'h0, 4'h0, "addi30", got, gf);
    check("addi30_word", got, 32'h0000_0F93);

    do_txn(1'b0, 32'h80, 32'hAABB_CCDD, 4'b0101, "wr80", got, gf);
    check("wr80_rdata", got, 32'h0);
    do_txn(1'b0, 32'h80, 32'h0, 4'h0, "rd80", got, gf);
    check("rd80_word", got, 32'h00BB_00DD);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, 71) * 4 + $urandom_range(0, 3));
      rd = $urandom;
      rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn(1'($urandom), ra, rd, rs, "rand", got, gf);
    end

    do_txn(1'b0, 32'h1000, 32'hDEAD_BEEF, 4'hF, "oob_wr", got, gf);
    check("oob_wr_fault", {31'h0, gf}, 32'h1);
    check("oob_wr_rdata", got, 32'h0);
    do_txn(1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, "oob_fetch", got, gf);
    for (int w = 0; w < DEPTH; w++)
      do_txn(1'b0, 32'(w * 4), 32'h0, 4'h0, "readback", got, gf);

    @(negedge clk);
    valid = 1'b1; instr = 1'b0; addr = 32'h0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_ready", {31'h0, ready}, 32'h0);
    end
    check_reset_outputs("abort");
    reset = 1'b0;
    model_reset();
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, "after_abort", got, gf);
    check("after_abort_word", got, 32'h0000_0093);

    i0[0] = 1'b1; i0[1] = 1'b0; i0[2] = 1'b1;
    for (int k = 0; k < 3; k++) a0[k] = 32'($urandom_range(0, DEPTH - 1) * 4);
    cnt0 = 32'h0;
    @(negedge clk);
    valid0 = 1'b1; instr0 = i0[0]; addr0 = a0[0]; wdata0 = $urandom; wstrb0 = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("ws0_gap", {31'h0, ready0}, 32'h0);
      if (k < 2) begin
        instr0 = i0[k + 1]; addr0 = a0[k + 1]; wdata0 = $urandom;
      end else begin
        valid0 = 1'b0;
      end
      if (i0[k]) cnt0++;
      @(posedge clk);
      @(negedge clk);
      check("ws0_ready", {31'h0, ready0}, 32'h1);
      check("ws0_rdata", rdata0, boot_img(int'(a0[k][7:2])));
      check("ws0_fault", {31'h0, fault0}, 32'h0);
      check("ws0_icnt", icnt0, cnt0);
    end
    @(posedge clk);
    @(negedge clk);
    check("ws0_end", {31'h0, ready0}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
